// File: rtl/id_decode_reg.sv
// IF/ID pipeline register: holds one fetched instruction behind a valid/ready
// handshake and presents its raw fields plus immediate-extend decode.

package id_decode_pkg;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_J     = 6'b000010,
      OP_JAL   = 6'b000011,
      OP_BEQ   = 6'b000100,
      OP_BNE   = 6'b000101,
      OP_ADDI  = 6'b001000,
      OP_ADDIU = 6'b001001,
      OP_SLTI  = 6'b001010,
      OP_SLTIU = 6'b001011,
      OP_ANDI  = 6'b001100,
      OP_ORI   = 6'b001101,
      OP_XORI  = 6'b001110,
      OP_LUI   = 6'b001111,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011
   } opcode_e;

   typedef struct packed {
      logic sext;
      logic imm_use;
      logic illegal;
   } dec_t;

   function automatic dec_t decode_op(input logic [5:0] op);
      dec_t d;
      // NOTE: every field gets a default before the case so no path leaves
      // it unassigned; the same rule keeps always_comb blocks latch-free.
      d = '{sext: 1'b0, imm_use: 1'b0, illegal: 1'b0};
      case (op)
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_BEQ,  OP_BNE,   OP_LW,   OP_SW: begin
            d.sext    = 1'b1;
            d.imm_use = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            d.imm_use = 1'b1;
         end
         OP_RTYPE, OP_J, OP_JAL: begin
            d = '{sext: 1'b0, imm_use: 1'b0, illegal: 1'b0};
         end
         default: begin
            d.illegal = 1'b1;
         end
      endcase
      return d;
   endfunction

endpackage

module id_decode_reg
   import id_decode_pkg::*;
#(
   parameter int          AW     = 32,
   parameter logic [AW-1:0] RESETV = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [31:0]   instr_in,
   input  logic [AW-1:0] pc_in,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          flush,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [AW-1:0] pc_out,
   output logic [5:0]    opcode,
   output logic [4:0]    rs,
   output logic [4:0]    rt,
   output logic [4:0]    rd,
   output logic [4:0]    shamt,
   output logic [5:0]    funct,
   output logic [15:0]   imm16,
   output logic          sext,
   output logic          imm_use,
   output logic          illegal
);

   logic [31:0]   instr_q;
   logic [AW-1:0] pc_q;
   logic          valid_q;
   logic          load;
   logic          drain;
   dec_t          dec;

   // Ready whenever the slot is empty or is being emptied this cycle.
   assign in_ready = !valid_q | out_ready;
   assign load     = in_valid & in_ready & !flush;
   assign drain    = valid_q & out_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q <= 1'b1;
      end else if (drain) begin
         valid_q <= 1'b0;
      end
   end

   // NOTE: the payload is reset too, because the field outputs must read as
   // zero (and pc_out as RESETV) straight out of reset, not as X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= '0;
         pc_q    <= RESETV;
      end else if (load) begin
         instr_q <= instr_in;
         pc_q    <= pc_in;
      end
   end

   // Decode follows the held word, so it only changes when a load happens.
   always_comb begin
      dec = decode_op(instr_q[31:26]);
   end

   assign out_valid = valid_q;
   assign pc_out    = pc_q;
   assign opcode    = instr_q[31:26];
   assign rs        = instr_q[25:21];
   assign rt        = instr_q[20:16];
   assign rd        = instr_q[15:11];
   assign shamt     = instr_q[10:6];
   assign funct     = instr_q[5:0];
   assign imm16     = instr_q[15:0];
   assign sext      = dec.sext;
   assign imm_use   = dec.imm_use;
   assign illegal   = dec.illegal;

endmodule

// File: tb/tb_id_decode_reg.sv
// Directed bench for id_decode_reg: a one-slot scoreboard tracks accepted
// instructions and checks each held/consumed output against it.

module tb_id_decode_reg;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   instr_in;
   logic [AW-1:0] pc_in;
   logic          in_valid;
   logic          in_ready;
   logic          flush;
   logic          out_ready;
   logic          out_valid;
   logic [AW-1:0] pc_out;
   logic [5:0]    opcode;
   logic [4:0]    rs, rt, rd, shamt;
   logic [5:0]    funct;
   logic [15:0]   imm16;
   logic          sext, imm_use, illegal;
   logic [31:0]   ext_out;

   typedef struct {
      logic [31:0]   instr;
      logic [AW-1:0] pc;
   } txn_t;

   txn_t sb[$];
   bit   mv;
   int   n_checks = 0;
   int   n_errors = 0;

   id_decode_reg #(.AW(AW), .RESETV('0)) dut (
      .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .pc_in(pc_in),
      .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .out_ready(out_ready), .out_valid(out_valid), .pc_out(pc_out),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
      .funct(funct), .imm16(imm16), .sext(sext), .imm_use(imm_use),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Downstream extend stage as it would see these outputs.
   assign ext_out = sext ? {{16{imm16[15]}}, imm16} : {16'h0000, imm16};

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   // {sext, imm_use, illegal} straight from the opcode table.
   function automatic logic [2:0] exp_flags(input logic [5:0] op);
      case (op)
         6'b001000, 6'b001001, 6'b001010, 6'b001011,
         6'b000100, 6'b000101, 6'b100011, 6'b101011: return 3'b110;
         6'b001100, 6'b001101, 6'b001110, 6'b001111: return 3'b010;
         6'b000000, 6'b000010, 6'b000011:            return 3'b000;
         default:                                    return 3'b001;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs at the falling edge against the model,
   // update the model with this cycle's handshake, then cross the rising edge.
   task automatic step(input logic v, input logic [31:0] ins, input logic [AW-1:0] pc,
                       input logic ordy, input logic fl);
      bit   exp_ready;
      bit   ld;
      txn_t t;
      in_valid  = v;
      instr_in  = ins;
      pc_in     = pc;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      exp_ready = !mv || ordy;
      check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
      check("out_valid", {63'd0, out_valid}, {63'd0, mv});
      if (mv && sb.size() > 0) begin
         t = sb[0];
         check("pc_out", {32'd0, pc_out}, {32'd0, t.pc});
         check("fields",
               {13'd0, opcode, rs, rt, rd, shamt, funct, imm16, sext, imm_use, illegal},
               {13'd0, t.instr[31:26], t.instr[25:21], t.instr[20:16], t.instr[15:11],
                t.instr[10:6], t.instr[5:0], t.instr[15:0], exp_flags(t.instr[31:26])});
      end
      ld = v && exp_ready && !fl;
      if (fl) begin
         if (mv) void'(sb.pop_front());
         mv = 1'b0;
      end else begin
         if (mv && ordy) begin
            void'(sb.pop_front());
            mv = 1'b0;
         end
         if (ld) begin
            t.instr = ins;
            t.pc    = pc;
            sb.push_back(t);
            mv = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] prog [8];
      prog = '{32'h8C620010, 32'hAC620014, 32'h10220003, 32'h08000040,
               32'h00221820, 32'h3C011234, 32'h38418001, 32'h2C41FFFF};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      instr_in  = '0;
      pc_in     = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      mv        = 1'b0;
      #3;
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_pc_out", {32'd0, pc_out}, 64'd0);
      check("rst_flags", {61'd0, sext, imm_use, illegal}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // addi $1,$2,0x8000: sign-extended immediate.
      step(1'b1, 32'h20418000, 32'h100, 1'b1, 1'b0);
      check("addi_imm16", {48'd0, imm16}, 64'h8000);
      check("addi_sext", {63'd0, sext}, 64'd1);
      check("addi_imm_use", {63'd0, imm_use}, 64'd1);
      check("addi_rs", {59'd0, rs}, 64'd2);
      check("addi_rt", {59'd0, rt}, 64'd1);
      check("addi_ext", {32'd0, ext_out}, 64'hFFFF8000);

      // ori $1,$2,0xFFFF: zero-extended immediate.
      step(1'b1, 32'h3441FFFF, 32'h104, 1'b1, 1'b0);
      check("ori_imm16", {48'd0, imm16}, 64'hFFFF);
      check("ori_sext", {63'd0, sext}, 64'd0);
      check("ori_ext", {32'd0, ext_out}, 64'h0000FFFF);

      // Stall: a lw is held for three cycles while a sw waits at the input.
      step(1'b1, 32'h8C410004, 32'h108, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 32'hAC410008, 32'h10C, 1'b0, 1'b0);
      step(1'b1, 32'hAC410008, 32'h10C, 1'b1, 1'b0);

      // Back-to-back: eight instructions, one per cycle, then drain.
      for (int i = 0; i < 8; i++) step(1'b1, prog[i], 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Flush while stalled and while draining: incoming word is dropped.
      step(1'b1, 32'h10220003, 32'h300, 1'b1, 1'b0);
      step(1'b1, 32'h2001000A, 32'h304, 1'b0, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step(1'b1, 32'h30A500FF, 32'h308, 1'b1, 1'b0);
      step(1'b1, 32'h2001000B, 32'h30C, 1'b1, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Unsupported opcode 111111 still passes through, flagged illegal.
      step(1'b1, 32'hFC221234, 32'h310, 1'b1, 1'b0);
      check("ill_illegal", {63'd0, illegal}, 64'd1);
      check("ill_imm_use", {63'd0, imm_use}, 64'd0);
      check("ill_opcode", {58'd0, opcode}, 64'h3F);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset mid-cycle with a valid addi held.
      step(1'b1, 32'h20418000, 32'h400, 1'b0, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", {63'd0, out_valid}, 64'd0);
      check("arst_pc_out", {32'd0, pc_out}, 64'd0);
      check("arst_sext", {63'd0, sext}, 64'd0);
      check("arst_in_ready", {63'd0, in_ready}, 64'd1);
      sb.delete();
      mv = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 32'h35290001, 32'h500, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
